sudoku_grid_mem: RTL and testbench
==================================

Name: sudoku_grid_mem

Overview:
Parametrised puzzle-grid memory, the writable multi-reader successor to the stimulus ROM. It is loaded once per puzzle over a valid/ready stream, then serves NCH independent read channels and one solver write port. It tracks given (fixed) cells and keeps a live count of empty cells. It sits between the stimulus source and the solver core.

Parameters:
WIDTH, 4, bits per cell value (0 = empty)
CELLS, 81, number of grid cells
NCH, 2, number of read channels
AW, $clog2(CELLS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
ld_valid  in  1  load beat valid
ld_ready  out  1  load beat accepted when valid&ready
ld_data  in  WIDTH  load cell value, row-major order
ld_last  in  1  marks final load beat
reload  in  1  one-cycle pulse, restart loading
load_done  out  1  grid loaded, memory active
load_err  out  1  sticky, ld_last position mismatch
rd_req  in  NCH  per-channel read request
rd_addr  in  NCH*AW  per-channel address, channel i at [i*AW +: AW]
rd_valid  out  NCH  per-channel read response valid
rd_data  out  NCH*WIDTH  per-channel read data
rd_fixed  out  NCH  per-channel given-cell flag
wr_en  in  1  solver write strobe
wr_addr  in  AW  write address
wr_data  in  WIDTH  write value
wr_err  out  1  one-cycle pulse, write rejected
empty_cnt  out  $clog2(CELLS+1)  number of cells holding 0

Behaviour:
- Reset (rst=0, async): state LOAD, load counter=0, all cells=0, fixed flags=0, ld_ready=1, load_done=0, load_err=0, rd_valid=0, rd_data=0, rd_fixed=0, wr_err=0, empty_cnt=CELLS.
- FSM has two states, LOAD and ACTIVE.
- LOAD: ld_ready=1. Each accepted beat writes cell[cnt]=ld_data and fixed[cnt]=(ld_data!=0), then cnt++. empty_cnt is decremented for each nonzero beat.
- Completion is by count. The beat with cnt==CELLS-1 moves to ACTIVE next cycle, with load_done=1 and ld_ready=0.
- ld_last on a beat with cnt!=CELLS-1: set load_err, set cnt=0, clear cells/fixed, set empty_cnt=CELLS, stay in LOAD.
- Final beat without ld_last: accepted, transition still happens, load_err set.
- ACTIVE: a reload pulse returns to LOAD next cycle. It clears cells, fixed flags, load_done, load_err and the counter, and sets empty_cnt=CELLS. reload in LOAD restarts the count identically.
- Reads are honoured only in ACTIVE. rd_req[i] at cycle t gives rd_valid[i]=1 at t+1, with rd_data/rd_fixed from rd_addr[i] sampled at t. This is 1-cycle latency and fully pipelined, so back-to-back requests are allowed.
- rd_valid[i]=0 when there is no request. rd_data/rd_fixed hold their last value.
- Read with address >= CELLS: rd_valid=1, rd_data=0, rd_fixed=0.
- Channels are independent. Same address on several channels returns identical data.
- Reads in LOAD: ignored, rd_valid=0.
- Write in ACTIVE at a valid, non-fixed address: cell updated at the clock edge.
- Read/write collision (same address, same cycle): the read returns the new wr_data (write-through).
- Rejected writes: fixed cell, address >= CELLS, or any write in LOAD. The cell is unchanged and wr_err=1 for the next cycle.
- empty_cnt on an accepted write: old==0 and new!=0 → -1. old!=0 and new==0 → +1. Otherwise unchanged. The value is visible the cycle after the write.
- reload and wr_en in the same cycle: reload wins. The write is dropped with no wr_err.
- Reset asserted mid-load or mid-operation: all state returns to reset values immediately.

Test Plan:
- Load 81 beats, values (i%10), ld_last on beat 80. Required: load_done=1 after beat 80; empty_cnt=9 (cells 0,10,...,80 hold 0); ld_ready=0.
- After that load, ch0 reads addr 1 and ch1 reads addr 10 in the same cycle. Required next cycle: rd_valid=2'b11; ch0 data=1, fixed=1; ch1 data=0, fixed=0.
- wr_en to addr 10 with value 5, with ch0 reading addr 10 in the same cycle. Required: ch0 rd_data=5; empty_cnt drops from 9 to 8; wr_err=0.
- Write to fixed addr 1, then to addr 81. Required: wr_err pulses one cycle each; addr 1 still reads 1; read of addr 81 returns rd_valid=1, data=0.
- ld_last asserted on beat 40. Required: load_err=1, counter restarts, load_done=0. A following correct 81-beat load completes with load_err still 1 until reload.
- reload in ACTIVE together with wr_en. Required: write dropped, wr_err=0, load_done=0, empty_cnt=81. Then async rst mid-load: all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/sudoku_grid_mem.sv
// sudoku_grid_mem: streamed-load puzzle grid with NCH read channels, one solver write port and a live empty-cell count
module sudoku_grid_mem #(
    parameter int WIDTH = 4,
    parameter int CELLS = 81,
    parameter int NCH = 2,
    localparam int AW = $clog2(CELLS),
    localparam int EW = $clog2(CELLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 ld_last,
    input  logic                 reload,
    output logic                 load_done,
    output logic                 load_err,
    input  logic [NCH-1:0]       rd_req,
    input  logic [NCH*AW-1:0]    rd_addr,
    output logic [NCH-1:0]       rd_valid,
    output logic [NCH*WIDTH-1:0] rd_data,
    output logic [NCH-1:0]       rd_fixed,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 wr_err,
    output logic [EW-1:0]        empty_cnt
);
    typedef enum logic {LOAD, ACTIVE} state_t;
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
    localparam logic [EW-1:0] FULL = EW'(CELLS);
    state_t state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cells_q [CELLS];
    logic [WIDTH-1:0] cells_d [CELLS];
    logic [CELLS-1:0] fixed_q, fixed_d;
    logic load_err_q, load_err_d, wr_err_q, wr_err_d;
    logic [NCH-1:0] rd_valid_q, rd_valid_d, rd_fixed_q, rd_fixed_d;
    logic [NCH*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [EW-1:0] empty_q, empty_d;
    logic active, beat, wr_ok;
    logic [AW-1:0] ra;

    assign active = state_q == ACTIVE;
    assign beat = !active && ld_valid && !reload;
    assign wr_ok = active && wr_en && !reload && wr_addr <= LAST && !fixed_q[wr_addr];

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        cells_d = cells_q;
        fixed_d = fixed_q;
        load_err_d = load_err_q;
        empty_d = empty_q;
        wr_err_d = wr_en && !reload && !wr_ok;
        rd_valid_d = '0;
        rd_data_d = rd_data_q;
        rd_fixed_d = rd_fixed_q;
        ra = '0;
        // a misplaced ld_last discards the partial grid just like reload, but flags the error
        if (reload || (beat && ld_last && cnt_q != LAST)) begin
            state_d = LOAD;
            cnt_d = '0;
            cells_d = '{default: '0};
            fixed_d = '0;
            empty_d = FULL;
            load_err_d = !reload;
        end else if (beat) begin
            cells_d[cnt_q] = ld_data;
            fixed_d[cnt_q] = ld_data != '0;
            empty_d = empty_q - EW'(ld_data != '0);
            cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == LAST ? ACTIVE : LOAD;
            load_err_d = load_err_q || (cnt_q == LAST && !ld_last);
        end else if (wr_ok) begin
            cells_d[wr_addr] = wr_data;
            empty_d = (cells_q[wr_addr] == '0 && wr_data != '0) ? empty_q - 1'b1 :
                      (cells_q[wr_addr] != '0 && wr_data == '0) ? empty_q + 1'b1 : empty_q;
        end
        for (int i = 0; i < NCH; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (active && rd_req[i]) begin
                rd_valid_d[i] = 1'b1;
                rd_data_d[i*WIDTH +: WIDTH] = (ra > LAST) ? '0 :
                                              (wr_ok && wr_addr == ra) ? wr_data : cells_q[ra];
                rd_fixed_d[i] = ra <= LAST && fixed_q[ra];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            cnt_q <= '0;
            cells_q <= '{default: '0};
            fixed_q <= '0;
            load_err_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_valid_q <= '0;
            rd_data_q <= '0;
            rd_fixed_q <= '0;
            empty_q <= FULL;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cells_q <= cells_d;
            fixed_q <= fixed_d;
            load_err_q <= load_err_d;
            wr_err_q <= wr_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q <= rd_data_d;
            rd_fixed_q <= rd_fixed_d;
            empty_q <= empty_d;
        end
    end

    assign ld_ready = !active;
    assign load_done = active;
    assign load_err = load_err_q;
    assign wr_err = wr_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data = rd_data_q;
    assign rd_fixed = rd_fixed_q;
    assign empty_cnt = empty_q;
endmodule

// File: tb/tb_sudoku_grid_mem.sv
// tb_sudoku_grid_mem: directed plan plus randomized traffic against a grid-level reference model
module tb_sudoku_grid_mem;
    localparam int N = 81;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ld_valid, ld_ready, ld_last, reload, load_done, load_err, wr_en, wr_err;
    logic [3:0] ld_data, wr_data;
    logic [1:0] rd_req, rd_valid, rd_fixed;
    logic [13:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] wr_addr, empty_cnt;

    int n_total = 0;
    int n_bad = 0;
    int m_cell [N];
    bit m_fix [N];
    bit m_active, m_err;
    int m_cnt;
    bit e_rv [2];
    bit e_rf [2];
    int e_rd [2];
    bit e_we;

    sudoku_grid_mem dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .ld_last(ld_last), .reload(reload), .load_done(load_done), .load_err(load_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_fixed(rd_fixed), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .empty_cnt(empty_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit err);
        for (int i = 0; i < N; i++) begin
            m_cell[i] = 0;
            m_fix[i] = 0;
        end
        m_cnt = 0;
        m_active = 0;
        m_err = err;
    endtask

    task automatic model_reset();
        model_clear(0);
        for (int c = 0; c < 2; c++) begin
            e_rv[c] = 0;
            e_rf[c] = 0;
            e_rd[c] = 0;
        end
        e_we = 0;
    endtask

    // Advance the grid model by one clock using the inputs currently applied.
    task automatic model_step();
        bit wacc;
        int a, wa;
        wa = int'(wr_addr);
        wacc = m_active && wr_en && !reload && (wa < N ? !m_fix[wa] : 1'b0);
        for (int c = 0; c < 2; c++) begin
            a = int'(rd_addr[c*7 +: 7]);
            e_rv[c] = m_active && rd_req[c];
            if (e_rv[c]) begin
                e_rd[c] = a >= N ? 0 : (wacc && wa == a) ? int'(wr_data) : m_cell[a];
                e_rf[c] = a >= N ? 1'b0 : m_fix[a];
            end
        end
        e_we = wr_en && !reload && !wacc;
        if (reload) model_clear(0);
        else if (!m_active && ld_valid) begin
            if (ld_last && m_cnt != N - 1) model_clear(1);
            else begin
                m_cell[m_cnt] = int'(ld_data);
                m_fix[m_cnt] = ld_data != 0;
                if (m_cnt == N - 1) begin
                    m_active = 1;
                    m_cnt = 0;
                    if (!ld_last) m_err = 1;
                end else m_cnt++;
            end
        end else if (wacc) m_cell[wa] = int'(wr_data);
    endtask

    task automatic compare_all();
        int z = 0;
        for (int i = 0; i < N; i++) if (m_cell[i] == 0) z++;
        chk("ld_ready", ld_ready, !m_active);
        chk("load_done", load_done, m_active);
        chk("load_err", load_err, m_err);
        chk("wr_err", wr_err, e_we);
        chk("empty_cnt", empty_cnt, z);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("rd_valid%0d", c), rd_valid[c], e_rv[c]);
            chk($sformatf("rd_data%0d", c), rd_data[c*4 +: 4], e_rd[c]);
            chk($sformatf("rd_fixed%0d", c), rd_fixed[c], e_rf[c]);
        end
    endtask

    task automatic idle();
        ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0;
        rd_req = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            idle();
            ld_valid = 1;
            ld_data = 4'(i % 10);
            ld_last = i == last_at;
            cycle();
        end
        idle();
    endtask

    function automatic logic [6:0] rand_addr();
        return $urandom_range(0, 9) == 0 ? 7'($urandom_range(N, 127)) : 7'($urandom_range(0, N - 1));
    endfunction

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_empty", empty_cnt, 81);
        chk("rst_ready", ld_ready, 1);
        rst = 1;

        load(N, N - 1);
        chk("lit_done", load_done, 1);
        chk("lit_ready", ld_ready, 0);
        chk("lit_empty9", empty_cnt, 9);

        rd_req = 2'b11; rd_addr = {7'd10, 7'd1};
        cycle();
        chk("lit_rv", rd_valid, 2'b11);
        chk("lit_rd0", rd_data[3:0], 1);
        chk("lit_rf0", rd_fixed[0], 1);
        chk("lit_rd1", rd_data[7:4], 0);
        chk("lit_rf1", rd_fixed[1], 0);

        idle(); wr_en = 1; wr_addr = 10; wr_data = 5; rd_req = 2'b01; rd_addr = {7'd0, 7'd10};
        cycle();
        chk("lit_wt", rd_data[3:0], 5);
        chk("lit_empty8", empty_cnt, 8);
        chk("lit_wrok", wr_err, 0);

        idle(); wr_en = 1; wr_addr = 1; wr_data = 7;
        cycle();
        chk("lit_werr_fix", wr_err, 1);
        idle(); wr_en = 1; wr_addr = 81; wr_data = 7;
        cycle();
        chk("lit_werr_oob", wr_err, 1);
        idle(); rd_req = 2'b11; rd_addr = {7'd81, 7'd1};
        cycle();
        chk("lit_werr_pulse", wr_err, 0);
        chk("lit_fix_kept", rd_data[3:0], 1);
        chk("lit_oob_v", rd_valid[1], 1);
        chk("lit_oob_d", rd_data[7:4], 0);

        idle(); reload = 1;
        cycle();
        idle();
        chk("lit_reload_done", load_done, 0);
        load(41, 40);
        chk("lit_lerr", load_err, 1);
        chk("lit_lerr_done", load_done, 0);
        chk("lit_lerr_empty", empty_cnt, 81);
        load(N, N - 1);
        chk("lit_lerr_sticky", load_err, 1);
        chk("lit_done2", load_done, 1);

        idle(); reload = 1; wr_en = 1; wr_addr = 10; wr_data = 3;
        cycle();
        idle();
        chk("lit_rw_werr", wr_err, 0);
        chk("lit_rw_done", load_done, 0);
        chk("lit_rw_empty", empty_cnt, 81);
        chk("lit_rw_lerr", load_err, 0);

        repeat (4000) begin
            idle();
            if (m_active) begin
                rd_req = 2'($urandom);
                for (int c = 0; c < 2; c++) rd_addr[c*7 +: 7] = rand_addr();
                wr_en = $urandom_range(0, 2) == 0;
                wr_addr = $urandom_range(0, 3) == 0 ? rd_addr[6:0] : rand_addr();
                wr_data = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
                reload = $urandom_range(0, 149) == 0;
            end else begin
                ld_valid = $urandom_range(0, 3) != 0;
                ld_data = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(1, 9));
                ld_last = m_cnt == N - 1 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 299) == 0;
                rd_req = 2'($urandom);
                rd_addr = 14'($urandom);
                wr_en = $urandom_range(0, 9) == 0;
                wr_addr = rand_addr();
                wr_data = 4'($urandom);
                reload = $urandom_range(0, 499) == 0;
            end
            cycle();
        end

        idle(); reload = 1;
        cycle();
        load(20, -1);
        #2 rst = 0;
        #1 model_reset();
        compare_all();
        chk("lit_arst_ready", ld_ready, 1);
        chk("lit_arst_empty", empty_cnt, 81);
        @(posedge clk);
        #1 compare_all();
        rst = 1;

        load(N, N - 1);
        rd_req = 2'b11; rd_addr = {7'd3, 7'd9};
        cycle();
        chk("lit_pre_rd", rd_data, 8'h39);
        #2 rst = 0;
        #1 model_reset();
        compare_all();
        chk("lit_arst_rv", rd_valid, 0);
        chk("lit_arst_rd", rd_data, 0);
        chk("lit_arst_done", load_done, 0);
        rst = 1;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
